regfile_nport: RTL and testbench
================================

# regfile_nport

Parametrised multi-read-port register file for the multicycle MIPS datapath, next generation of the two-read/one-write file. Adds a configurable number of read ports and a hardwired zero register. A reset-driven clear sequencer zeroes every entry one per cycle and reports `busy`, replacing memory-file initialisation. Optional write-to-read bypass. Sits between instruction decode (address fields) and the A/B operand registers; the write port is driven by the controller's register-write enable.

## Interface
Parameters:
- `ADDR_WIDTH`, 5: address bits; depth = 2**ADDR_WIDTH entries.
- `DATA_WIDTH`, 32: bits per entry.
- `NREAD`, 2: number of independent read ports, 1..4.

Ports:
- `clk`  in  1  sole clock, all state updates on posedge.
- `reset`  in  1  synchronous, active-high; starts the clear sequence.
- `we`  in  1  write enable from the controller.
- `wa`  in  ADDR_WIDTH  write address.
- `wd`  in  DATA_WIDTH  write data.
- `ra`  in  NREAD*ADDR_WIDTH  read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- `rd`  out  NREAD*DATA_WIDTH  read data; port k on [k*DATA_WIDTH +: DATA_WIDTH].
- `busy`  out  1  high while the clear sequence runs; the controller stalls on it.

## Operation
- States: CLEAR, READY. A 2-bit state register is allowed; a 1-bit register is sufficient.
- CLEAR:
  - Clear counter `cnt` (ADDR_WIDTH+1 bits) writes 0 to entry `cnt[ADDR_WIDTH-1:0]` each cycle and increments.
  - Leaves for READY on the edge that clears entry 2**ADDR_WIDTH-1.
  - `we` is ignored and `busy` is 1.
  - All `rd` ports return 0, regardless of address or bypass.
- READY:
  - On posedge, if `we` and `wa` != 0, `mem[wa] <= wd`.
  - Writes to address 0 are dropped.
- Reads are combinational and asynchronous.
  - `rd[k] = 0` if `ra[k]` == 0, otherwise `mem[ra[k]]`.
  - Ports are fully independent; any number of ports may read the same address.
- Entry 0 is never stored to. It may be omitted from storage.

## Timing
- `reset` sampled high at an edge gives state=CLEAR, `cnt`=0, `busy`=1 after that edge.
  - While `reset` stays high, `cnt` holds 0 and no entry is cleared.
- Taking E0 as the last edge with `reset` high:
  - Edges E1..E(2**ADDR_WIDTH) clear entries 0..2**ADDR_WIDTH-1.
  - `busy` falls after E(2**ADDR_WIDTH); 32 cycles for the default parameters.
  - The first accepted write is at edge E(2**ADDR_WIDTH+1).
- Reset asserted mid-clear restarts `cnt` at 0.
- Reset asserted in READY discards a same-cycle write; reset has priority over `we`.
- Write latency: 1 edge. Without bypass, a read of `wa` in the write cycle returns the old value and the new value after the edge.
- Output values before the first reset are undefined. Benches must reset first.
- `busy` reset value is 1. `rd` is 0 for all ports from the reset edge until `busy` falls.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - In READY, if `we` and `wa` != 0 and `ra[k]` == `wa`, then `rd[k]` = `wd` combinationally in the same cycle.
  - Zero-register and CLEAR rules still take priority.
- `REGFILE_BYPASS_EN` undefined: no forwarding; reads return stored contents only.

## Test plan
- Reset 2 cycles, then release: `busy`=1 for exactly 32 cycles and falls after the 32nd edge. All `rd`=0 throughout. After `busy` falls, every address reads 0.
- In READY, write 0xDEADBEEF to 5 and 0x12345678 to 31. Set `ra` = {31,5}: `rd` = {0x12345678, 0xDEADBEEF} the cycle after the second write. Write 0xFFFFFFFF to 0: reads of 0 stay 0.
- Set `we`=1, `wa`=7, `wd`=0xA5A5A5A5, `ra0`=7 in one cycle:
  - With `REGFILE_BYPASS_EN`: `rd0`=0xA5A5A5A5 in that cycle.
  - Without it: `rd0` holds the prior value 0, then 0xA5A5A5A5 after the edge.
- Fill entries with nonzero data, then assert reset for 1 cycle and deassert. At clear cycle 10, reassert reset for 1 cycle. Check `busy` stays high 32 more cycles after the second release and all entries read 0.
- With `busy`=1, drive `we`=1, `wa`=3, `wd`=0x55. After `busy` falls, entry 3 reads 0.
- With `NREAD`=4, load addresses 1..4 with 0x11..0x44 and set `ra`={4,3,2,1}: `rd`={0x44,0x33,0x22,0x11}. Set all ports to address 2: all read 0x22.

Source files
------------

// File: rtl/regfile_nport.sv
// rtl/regfile_nport.sv - multi-read-port register file with zero register, clear sequencer and optional bypass (REGFILE_BYPASS_EN)
module regfile_nport #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NREAD      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we,
    input  logic [ADDR_WIDTH-1:0]         wa,
    input  logic [DATA_WIDTH-1:0]         wd,
    input  logic [NREAD*ADDR_WIDTH-1:0]   ra,
    output logic [NREAD*DATA_WIDTH-1:0]   rd,
    output logic                          busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH:0]     cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    last_clear;
    logic                    write_ok;

    assign last_clear = (cnt[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});
    assign write_ok   = we && (wa != '0);
    assign busy       = (state == CLEAR);

    // State register; reset always returns to CLEAR
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next state: CLEAR exits on the edge that clears the last entry
    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (last_clear) state_next = READY;
            READY:   state_next = READY;
            default: state_next = CLEAR;
        endcase
    end

    // Clear counter: held at 0 while reset is high, advances one entry per CLEAR cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
    end

    // Storage update: clear sequencer owns the array in CLEAR, writes to entry 0 are dropped
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[cnt[ADDR_WIDTH-1:0]] <= '0;
            end else if (write_ok) begin
                mem[wa] <= wd;
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;

        assign addr = ra[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Asynchronous read: zero during CLEAR and for the zero register
        always_comb begin
            data = '0;
            if (state == READY && addr != '0) begin
                data = mem[addr];
`ifdef REGFILE_BYPASS_EN
                if (write_ok && addr == wa) begin
                    data = wd;
                end
`else
`endif
            end
        end

        assign rd[k*DATA_WIDTH +: DATA_WIDTH] = data;
    end

endmodule

// File: tb/tb_regfile_nport.sv
// tb/tb_regfile_nport.sv - directed self-checking bench for regfile_nport
module tb_regfile_nport;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 4;

    logic             clk;
    logic             reset;
    logic             we;
    logic [AW-1:0]    wa;
    logic [DW-1:0]    wd;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic             busy;

    int n_tests;
    int n_fail;

    regfile_nport #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NREAD(NR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .we(we),
        .wa(wa),
        .wd(wd),
        .ra(ra),
        .rd(rd),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [AW-1:0] a3, input logic [AW-1:0] a2,
                          input logic [AW-1:0] a1, input logic [AW-1:0] a0);
        ra = {a3, a2, a1, a0};
        #1;
    endtask

    function automatic logic [DW-1:0] port(input int k);
        return rd[k*DW +: DW];
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1;
        wa = a;
        wd = d;
        step();
        we = 1'b0;
        #1;
    endtask

    task automatic clear_run(input string tag);
        for (int i = 1; i <= 32; i++) begin
            step();
            check({tag, "_busy"}, {31'd0, busy}, (i < 32) ? 32'd1 : 32'd0);
            if (i < 32) begin
                check({tag, "_rd0_clear"}, port(0), 32'd0);
                check({tag, "_rd3_clear"}, port(3), 32'd0);
            end
        end
    endtask

    task automatic all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            set_ra(5'd0, 5'd0, 5'd0, a[AW-1:0]);
            check(tag, port(0), 32'd0);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        we      = 1'b0;
        wa      = '0;
        wd      = '0;
        ra      = {5'd4, 5'd3, 5'd2, 5'd1};

        // Two reset cycles
        step();
        check("reset_busy", {31'd0, busy}, 32'd1);
        check("reset_rd0", port(0), 32'd0);
        step();
        reset = 1'b0;
        #1;
        clear_run("clr1");
        all_zero("clr1_all_zero");

        // Basic writes and two-port read
        write(5'd5, 32'hDEADBEEF);
        write(5'd31, 32'h12345678);
        set_ra(5'd0, 5'd0, 5'd31, 5'd5);
        check("rd_port0_addr5", port(0), 32'hDEADBEEF);
        check("rd_port1_addr31", port(1), 32'h12345678);

        // Writes to the zero register are dropped
        write(5'd0, 32'hFFFFFFFF);
        set_ra(5'd0, 5'd0, 5'd0, 5'd0);
        check("zero_reg_port0", port(0), 32'd0);
        check("zero_reg_port1", port(1), 32'd0);

        // Same-cycle write/read of address 7
        we = 1'b1;
        wa = 5'd7;
        wd = 32'hA5A5A5A5;
        set_ra(5'd0, 5'd0, 5'd0, 5'd7);
`ifdef REGFILE_BYPASS_EN
        check("same_cycle_rd7", port(0), 32'hA5A5A5A5);
`else
        check("same_cycle_rd7", port(0), 32'd0);
`endif
        step();
        we = 1'b0;
        #1;
        check("after_edge_rd7", port(0), 32'hA5A5A5A5);

        // Four independent ports
        write(5'd1, 32'h11);
        write(5'd2, 32'h22);
        write(5'd3, 32'h33);
        write(5'd4, 32'h44);
        set_ra(5'd4, 5'd3, 5'd2, 5'd1);
        check("nport_p0", port(0), 32'h11);
        check("nport_p1", port(1), 32'h22);
        check("nport_p2", port(2), 32'h33);
        check("nport_p3", port(3), 32'h44);
        set_ra(5'd2, 5'd2, 5'd2, 5'd2);
        for (int k = 0; k < NR; k++) begin
            check("same_addr_all_ports", port(k), 32'h22);
        end

        // Reset, restart mid-clear at cycle 10, writes ignored while busy
        reset = 1'b1;
        step();
        reset = 1'b0;
        we = 1'b1;
        wa = 5'd3;
        wd = 32'h55;
        set_ra(5'd4, 5'd3, 5'd2, 5'd1);
        for (int i = 1; i <= 10; i++) begin
            step();
            check("first_clear_busy", {31'd0, busy}, 32'd1);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        clear_run("clr2");
        we = 1'b0;
        #1;
        all_zero("clr2_all_zero");
        set_ra(5'd0, 5'd0, 5'd0, 5'd3);
        check("busy_write_dropped", port(0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
